// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data SRAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } arb_gnt_e;

  // Same polarity as the core's `READ / `WRITE macros.
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/arb_wait_timer.sv
// Loadable down-counter that times one SRAM access; last_o marks the final access cycle.
module arb_wait_timer #(
  parameter int WAIT_CYCLES = 2,
  parameter int CW          = $clog2(WAIT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic last_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = CW'(WAIT_CYCLES - 1);
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port SRAM between fetch and MEM data ports.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_sel,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          stall_req,
  output logic          sram_ce,
  output logic          sram_we,
  output logic [3:0]    sram_be,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
);

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("mem_bus_arbiter: WAIT_CYCLES must be >= 1");
  end

  arb_state_e    state_q, state_d;
  arb_gnt_e      gnt_q, gnt_d, last_q, last_d;
  logic          lat_en, tmr_last, in_acc;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [DW-1:0] wdata_q, if_rdata_q, d_rdata_q;

  arb_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (lat_en),
    .dec_i  (in_acc),
    .last_o (tmr_last)
  );

  assign in_acc = (state_q == ST_ACCESS);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    lat_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (d_req || if_req) begin
          // On contention the port that lost last time wins.
          if (d_req && if_req) gnt_d = (last_q == GNT_IF) ? GNT_D : GNT_IF;
          else                 gnt_d = d_req ? GNT_D : GNT_IF;
          last_d  = gnt_d;
          lat_en  = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: if (tmr_last) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= GNT_IF;
      last_q     <= GNT_IF;
      addr_q     <= '0;
      we_q       <= RW_READ;
      be_q       <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      if (lat_en) begin
        if (gnt_d == GNT_D) begin
          addr_q  <= d_addr;
          we_q    <= d_we;
          be_q    <= d_sel;
          wdata_q <= d_wdata;
        end else begin
          addr_q  <= if_addr;
          we_q    <= RW_READ;
          be_q    <= 4'b1111;
          wdata_q <= '0;
        end
      end
      // Read data is valid only in the final access cycle.
      if (in_acc && tmr_last && we_q == RW_READ) begin
        if (gnt_q == GNT_D) d_rdata_q  <= sram_rdata;
        else                if_rdata_q <= sram_rdata;
      end
    end
  end

  assign sram_ce    = in_acc;
  assign sram_we    = in_acc & we_q;
  assign sram_be    = in_acc ? be_q    : '0;
  assign sram_addr  = in_acc ? addr_q  : '0;
  assign sram_wdata = in_acc ? wdata_q : '0;

  assign if_ack   = (state_q == ST_RESP) && (gnt_q == GNT_IF);
  assign d_ack    = (state_q == ST_RESP) && (gnt_q == GNT_D);
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

  assign stall_req = ~rst & ((d_req & ~d_ack) | (if_req & ~if_ack));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: WAIT_CYCLES=2 instance plus a WAIT_CYCLES=1 instance.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          nchk = 0;
  int          nerr = 0;

  logic        if_req, if_ack, d_req, d_we, d_ack, stall_req, sram_ce, sram_we;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, sram_addr, sram_wdata, sram_rdata;
  logic [3:0]  d_sel, sram_be;

  logic        b_if_req, b_if_ack, b_d_req, b_d_we, b_d_ack, b_stall_req, b_sram_ce, b_sram_we;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_sram_addr, b_sram_wdata, b_sram_rdata;
  logic [3:0]  b_d_sel, b_sram_be;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.DW(32), .AW(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .stall_req(stall_req),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_be(sram_be), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  mem_bus_arbiter #(.DW(32), .AW(32), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .d_req(b_d_req), .d_we(b_d_we), .d_sel(b_d_sel), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ack(b_d_ack), .stall_req(b_stall_req),
    .sram_ce(b_sram_ce), .sram_we(b_sram_we), .sram_be(b_sram_be), .sram_addr(b_sram_addr),
    .sram_wdata(b_sram_wdata), .sram_rdata(b_sram_rdata)
  );

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    #4;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_sel = 0; d_addr = 0; d_wdata = 0; sram_rdata = 0;
    b_if_req = 0; b_if_addr = 0; b_d_req = 0; b_d_we = 0; b_d_sel = 0; b_d_addr = 0; b_d_wdata = 0;
    b_sram_rdata = 0;

    // reset state, stall masked while rst is high
    nxt; d_req = 1; smp;
    chk("rst_stall", stall_req, 0);
    chk("rst_ce", sram_ce, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_addr", sram_addr, 0);
    nxt; rst = 0; d_req = 0; smp;
    chk("idle_ce", sram_ce, 0);

    // lone fetch
    nxt; if_req = 1; if_addr = 32'h100; sram_rdata = 32'h3C011234; smp;
    chk("f_c0_stall", stall_req, 1);
    chk("f_c0_ce", sram_ce, 0);
    for (int c = 1; c <= 2; c++) begin
      nxt; smp;
      chk("f_ce", sram_ce, 1);
      chk("f_be", sram_be, 4'hF);
      chk("f_we", sram_we, 0);
      chk("f_addr", sram_addr, 32'h100);
      chk("f_wdata", sram_wdata, 0);
      chk("f_stall", stall_req, 1);
    end
    nxt; smp;
    chk("f_ack", if_ack, 1);
    chk("f_rdata", if_rdata, 32'h3C011234);
    chk("f_c3_stall", stall_req, 0);
    chk("f_c3_ce", sram_ce, 0);
    nxt; if_req = 0; smp;
    chk("f_ack_pulse", if_ack, 0);
    chk("f_rdata_hold", if_rdata, 32'h3C011234);

    // byte write; address change after grant must be ignored
    nxt; d_req = 1; d_we = 1; d_sel = 4'b0001; d_addr = 32'h203; d_wdata = 32'hABABABAB;
    sram_rdata = 32'h55555555; smp;
    for (int c = 1; c <= 2; c++) begin
      nxt; d_addr = 32'h0FFC; smp;
      chk("w_ce", sram_ce, 1);
      chk("w_we", sram_we, 1);
      chk("w_be", sram_be, 4'b0001);
      chk("w_addr", sram_addr, 32'h203);
      chk("w_wdata", sram_wdata, 32'hABABABAB);
    end
    nxt; smp;
    chk("w_ack", d_ack, 1);
    chk("w_if_ack", if_ack, 0);
    chk("w_rdata_kept", d_rdata, 0);
    nxt; d_req = 0; d_we = 0; smp;
    chk("w_ack_pulse", d_ack, 0);

    // both rise together after reset: D wins first
    nxt; rst = 1; smp;
    nxt; rst = 0; if_req = 1; if_addr = 32'h140; d_req = 1; d_sel = 4'hF; d_addr = 32'h380;
    sram_rdata = 32'h11112222; smp;
    chk("b_c0_stall", stall_req, 1);
    nxt; smp;
    chk("b_c1_addr", sram_addr, 32'h380);
    chk("b_c1_we", sram_we, 0);
    nxt; smp;
    nxt; smp;
    chk("b_c3_d_ack", d_ack, 1);
    chk("b_c3_if_ack", if_ack, 0);
    chk("b_c3_d_rdata", d_rdata, 32'h11112222);
    chk("b_c3_stall", stall_req, 1);
    nxt; d_req = 0; sram_rdata = 32'h33334444; smp;
    chk("b_c4_ce", sram_ce, 0);
    chk("b_c4_stall", stall_req, 1);
    nxt; smp;
    chk("b_c5_addr", sram_addr, 32'h140);
    chk("b_c5_be", sram_be, 4'hF);
    nxt; smp;
    nxt; smp;
    chk("b_c7_if_ack", if_ack, 1);
    chk("b_c7_d_ack", d_ack, 0);
    chk("b_c7_if_rdata", if_rdata, 32'h33334444);

    // both held for four transactions: D, IF, D, IF
    nxt; d_req = 1; d_addr = 32'h3A0; smp;
    for (int c = 0; c < 16; c++) begin
      if (c != 0) begin nxt; smp; end
      chk("rr_d_ack", d_ack, (c == 3 || c == 11) ? 1 : 0);
      chk("rr_if_ack", if_ack, (c == 7 || c == 15) ? 1 : 0);
      if (c % 4 == 1) chk("rr_addr", sram_addr, (c == 1 || c == 9) ? 32'h3A0 : 32'h140);
    end
    nxt; d_req = 0; if_req = 0; smp;
    chk("rr_idle_ce", sram_ce, 0);

    // d_sel = 0 still runs and acks
    nxt; d_req = 1; d_we = 0; d_sel = 4'b0000; d_addr = 32'h3C0; sram_rdata = 32'h0BADF00D; smp;
    nxt; smp;
    chk("z_ce", sram_ce, 1);
    chk("z_be", sram_be, 0);
    nxt; smp;
    nxt; smp;
    chk("z_ack", d_ack, 1);
    chk("z_rdata", d_rdata, 32'h0BADF00D);
    nxt; d_req = 0; smp;

    // reset in cycle 2 of a data read, request held through it
    nxt; d_req = 1; d_sel = 4'hF; d_addr = 32'h300; sram_rdata = 32'hCAFEF00D; smp;
    nxt; smp;
    chk("r_c1_ce", sram_ce, 1);
    nxt; rst = 1; smp;
    chk("r_c2_ce", sram_ce, 1);
    chk("r_c2_stall", stall_req, 0);
    nxt; rst = 0; smp;
    chk("r_c3_ce", sram_ce, 0);
    chk("r_c3_ack", d_ack, 0);
    chk("r_c3_addr", sram_addr, 0);
    chk("r_c3_rdata", d_rdata, 0);
    nxt; smp;
    chk("r_c4_ce", sram_ce, 1);
    chk("r_c4_addr", sram_addr, 32'h300);
    nxt; smp;
    chk("r_c5_ack", d_ack, 0);
    nxt; smp;
    chk("r_c6_ack", d_ack, 1);
    chk("r_c6_rdata", d_rdata, 32'hCAFEF00D);
    nxt; d_req = 0; smp;

    // WAIT_CYCLES = 1 build
    nxt; b_d_req = 1; b_d_sel = 4'hF; b_d_addr = 32'h44; b_sram_rdata = 32'hDEADBEEF; smp;
    chk("w1_c0_ce", b_sram_ce, 0);
    nxt; smp;
    chk("w1_c1_ce", b_sram_ce, 1);
    chk("w1_c1_ack", b_d_ack, 0);
    nxt; smp;
    chk("w1_c2_ce", b_sram_ce, 0);
    chk("w1_c2_ack", b_d_ack, 1);
    chk("w1_c2_rdata", b_d_rdata, 32'hDEADBEEF);
    nxt; b_d_req = 0; smp;
    chk("w1_c3_ack", b_d_ack, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
